decode_hazard_ctrl: RTL and testbench
=====================================

// Module: decode_hazard_ctrl
// PURPOSE
//  Register scoreboard and issue controller for the decode stage. Tracks in-flight
//  register writes between decode issue and write-back retire. Stalls decode on RAW
//  hazards and on WAW counter overflow. Runs a drain handshake (fence/ecall) that
//  holds issue until the pipeline has no pending writes.
// PARAMETERS
//  MAX_INFLIGHT  3  max outstanding writes per register (counter width = $clog2(MAX_INFLIGHT+1))
// PORTS
//  clk_i              in   1  clock, rising edge
//  rst_i              in   1  asynchronous, active-low reset
//  raddr1_i           in   5  decode source register 1
//  raddr1_used_i      in   1  instruction reads raddr1_i
//  raddr2_i           in   5  decode source register 2
//  raddr2_used_i      in   1  instruction reads raddr2_i
//  issue_valid_i      in   1  decode output_valid (instruction offered to execute)
//  issue_ready_i      in   1  execute output_ready
//  issue_reg_write_i  in   1  issued instruction writes rd
//  issue_reg_addr_i   in   5  issued rd
//  retire_valid_i     in   1  one writing instr leaves pipe (committed or squashed)
//  retire_reg_addr_i  in   5  rd of retiring instruction
//  drain_req_i        in   1  request pipeline drain; level, held until drain_ack_o seen
//  stall_o            out  1  decode must not issue (gates decode input_ready/output_valid)
//  busy_o             out  1  at least one register pending
//  drain_ack_o        out  1  single-cycle pulse: pipeline empty, drain granted
//  error_o            out  1  sticky: retire with no matching pending write
// BEHAVIOUR
//  - cnt[r], r=1..31: pending writes. x0 never tracked: issue/retire to addr 0 ignored,
//    and sources equal to 0 never hazard.
//  - Issue event: issue_valid_i & issue_ready_i & issue_reg_write_i & rd!=0 -> cnt[rd]+1.
//  - Retire event: retire_valid_i & addr!=0 -> cnt[addr]-1.
//    * Same register, same cycle: cnt unchanged.
//    * Retire with cnt==0 (no simultaneous issue): cnt stays 0, error_o<=1 until reset.
//  - hazard (combinational from registered counters, no retire bypass) =
//      (raddr1_used_i & cnt[raddr1_i]!=0) | (raddr2_used_i & cnt[raddr2_i]!=0)
//      | (issue_reg_write_i & cnt[issue_reg_addr_i]==MAX_INFLIGHT).
//    A retire at edge N clears the hazard from cycle N+1; the RF write has landed by then.
//  - busy_o = OR of all cnt!=0 (registered counters).
//  - FSM states RUN, DRAIN, HOLD:
//    * RUN: stall_o=hazard. drain_req_i=1 -> DRAIN.
//    * DRAIN: stall_o=1. When busy_o==0, pulse drain_ack_o for 1 cycle -> HOLD.
//      If busy_o is already 0 on entry, the ack comes on the first DRAIN cycle.
//    * HOLD: stall_o=1. When drain_req_i==0 -> RUN.
//    * drain_req_i dropped in DRAIN: return to RUN, no ack.
//  - Issues accepted in the same cycle the FSM enters DRAIN are still counted.
//  - Reset (async assert, any state): all cnt=0, state=RUN, drain_ack_o=0, error_o=0.
//    This gives stall_o=0 and busy_o=0. Release takes effect at the next clk_i edge.
// TESTING
//  1. Issue wr x5, next cycle raddr1=x5 used -> stall_o=1. Retire x5 -> stall_o=0 one cycle later.
//  2. raddr1=x0 used, issue wr x0 -> cnt unchanged, stall_o=0, busy_o=0.
//  3. Three issues to x7 (MAX=3), 4th instr writes x7 -> stall_o=1. One retire -> stall drops.
//  4. Issue and retire x9 same cycle with cnt[x9]=1 -> cnt stays 1, stall on x9 read persists.
//  5. Pending x3,x4; drain_req_i=1 -> stall_o=1. Retire both -> drain_ack_o pulses once.
//     Stall held until drain_req_i=0, then RUN.
//  6. Retire x12 with cnt=0 -> error_o=1 sticky. rst_i low mid-DRAIN -> all outputs 0, RUN.

Source files
------------

// File: rtl/decode_hazard_ctrl.sv
// Decode-stage register scoreboard: counts in-flight writes per register, stalls
// issue on RAW hazards or a saturated WAW counter, and runs the fence/ecall drain handshake.
module decode_hazard_ctrl #(
   parameter int MAX_INFLIGHT = 3
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [4:0] raddr1_i,
   input  logic       raddr1_used_i,
   input  logic [4:0] raddr2_i,
   input  logic       raddr2_used_i,
   input  logic       issue_valid_i,
   input  logic       issue_ready_i,
   input  logic       issue_reg_write_i,
   input  logic [4:0] issue_reg_addr_i,
   input  logic       retire_valid_i,
   input  logic [4:0] retire_reg_addr_i,
   input  logic       drain_req_i,
   output logic       stall_o,
   output logic       busy_o,
   output logic       drain_ack_o,
   output logic       error_o
);
   localparam int CW = $clog2(MAX_INFLIGHT + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_INFLIGHT);

   typedef enum logic [1:0] {RUN, DRAIN, HOLD} state_t;

   state_t        state_reg;
   logic          error_reg;
   logic [CW-1:0] cnt_vec [32];
   logic [31:0]   busy_vec;
   logic [31:0]   under_vec;
   logic          issue_fire;
   logic          hazard;
   logic          busy;

   assign issue_fire = issue_valid_i & issue_ready_i & issue_reg_write_i;

   genvar gi;
   generate
      for (gi = 0; gi < 32; gi++) begin : g_cnt
         if (gi == 0) begin : g_zero
            // x0 is hardwired: never pending, never hazards, never underflows
            assign cnt_vec[gi]   = '0;
            assign busy_vec[gi]  = 1'b0;
            assign under_vec[gi] = 1'b0;
         end else begin : g_track
            logic          inc;
            logic          dec;
            logic [CW-1:0] cnt_reg;

            assign inc = issue_fire & (issue_reg_addr_i == 5'(gi));
            assign dec = retire_valid_i & (retire_reg_addr_i == 5'(gi));

            // Issue and retire of the same register cancel; counter never wraps either way
            always_ff @(posedge clk_i or negedge rst_i) begin
               if (!rst_i) begin
                  cnt_reg <= '0;
               end else if (inc && !dec && cnt_reg != CNT_MAX) begin
                  cnt_reg <= cnt_reg + 1'b1;
               end else if (dec && !inc && cnt_reg != '0) begin
                  cnt_reg <= cnt_reg - 1'b1;
               end
            end

            assign cnt_vec[gi]   = cnt_reg;
            assign busy_vec[gi]  = (cnt_reg != '0);
            assign under_vec[gi] = dec & ~inc & (cnt_reg == '0);
         end
      end
   endgenerate

   assign busy   = |busy_vec;
   assign hazard = (raddr1_used_i & (cnt_vec[raddr1_i] != '0))
                 | (raddr2_used_i & (cnt_vec[raddr2_i] != '0))
                 | (issue_reg_write_i & (cnt_vec[issue_reg_addr_i] == CNT_MAX));

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_reg <= RUN;
      end else begin
         case (state_reg)
            RUN:     if (drain_req_i) state_reg <= DRAIN;
            DRAIN: begin
               if (!drain_req_i)  state_reg <= RUN;
               else if (!busy)    state_reg <= HOLD;
            end
            HOLD:    if (!drain_req_i) state_reg <= RUN;
            default: state_reg <= RUN;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         error_reg <= 1'b0;
      end else if (|under_vec) begin
         error_reg <= 1'b1;
      end
   end

   // Ack is decoded from registered state so it can fire on the very first DRAIN cycle
   assign drain_ack_o = (state_reg == DRAIN) & drain_req_i & ~busy;
   assign stall_o     = (state_reg != RUN) | hazard;
   assign busy_o      = busy;
   assign error_o     = error_reg;
endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Bench for decode_hazard_ctrl: directed vector table, hand sequences for drain/error/reset,
// then randomized traffic against a per-register count model.
module tb_decode_hazard_ctrl;
   logic       clk_i = 1'b0;
   logic       rst_i = 1'b0;
   logic [4:0] raddr1_i = '0;
   logic       raddr1_used_i = 1'b0;
   logic [4:0] raddr2_i = '0;
   logic       raddr2_used_i = 1'b0;
   logic       issue_valid_i = 1'b0;
   logic       issue_ready_i = 1'b0;
   logic       issue_reg_write_i = 1'b0;
   logic [4:0] issue_reg_addr_i = '0;
   logic       retire_valid_i = 1'b0;
   logic [4:0] retire_reg_addr_i = '0;
   logic       drain_req_i = 1'b0;
   logic       stall_o, busy_o, drain_ack_o, error_o;

   int checks = 0;
   int failures = 0;

   decode_hazard_ctrl #(.MAX_INFLIGHT(3)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .raddr1_i(raddr1_i), .raddr1_used_i(raddr1_used_i),
      .raddr2_i(raddr2_i), .raddr2_used_i(raddr2_used_i),
      .issue_valid_i(issue_valid_i), .issue_ready_i(issue_ready_i),
      .issue_reg_write_i(issue_reg_write_i), .issue_reg_addr_i(issue_reg_addr_i),
      .retire_valid_i(retire_valid_i), .retire_reg_addr_i(retire_reg_addr_i),
      .drain_req_i(drain_req_i),
      .stall_o(stall_o), .busy_o(busy_o), .drain_ack_o(drain_ack_o), .error_o(error_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [4:0] r1; logic r1u; logic [4:0] r2; logic r2u;
      logic iv; logic ir; logic iw; logic [4:0] ia;
      logic rv; logic [4:0] ra; logic dr;
      logic e_stall; logic e_busy; logic e_ack; logic e_err;
   } vec_t;

   function automatic vec_t mk(input logic [4:0] r1, input logic r1u,
                               input logic [4:0] r2, input logic r2u,
                               input logic iss, input logic iw, input logic [4:0] ia,
                               input logic rv, input logic [4:0] ra, input logic dr,
                               input logic s, input logic b, input logic a, input logic e);
      vec_t v;
      v.r1 = r1; v.r1u = r1u; v.r2 = r2; v.r2u = r2u;
      v.iv = iss; v.ir = iss; v.iw = iw; v.ia = ia;
      v.rv = rv; v.ra = ra; v.dr = dr;
      v.e_stall = s; v.e_busy = b; v.e_ack = a; v.e_err = e;
      return v;
   endfunction

   task automatic chk(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0b required=%0b", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      raddr1_i = v.r1; raddr1_used_i = v.r1u; raddr2_i = v.r2; raddr2_used_i = v.r2u;
      issue_valid_i = v.iv; issue_ready_i = v.ir; issue_reg_write_i = v.iw;
      issue_reg_addr_i = v.ia; retire_valid_i = v.rv; retire_reg_addr_i = v.ra;
      drain_req_i = v.dr;
   endtask

   // One cycle: drive after the rising edge, sample at the falling edge
   task automatic step(input vec_t v, input string tag);
      @(posedge clk_i);
      #1;
      drive(v);
      @(negedge clk_i);
      $display("%s stall=%0b busy=%0b ack=%0b err=%0b", tag, stall_o, busy_o, drain_ack_o, error_o);
      chk({tag, ".stall"}, stall_o, v.e_stall);
      chk({tag, ".busy"}, busy_o, v.e_busy);
      chk({tag, ".ack"}, drain_ack_o, v.e_ack);
      chk({tag, ".err"}, error_o, v.e_err);
   endtask

   vec_t tbl[22];
   vec_t seq[$];
   vec_t idle;

   // reference model state
   int   cm[32];
   int   mode;   // 0 run, 1 drain, 2 hold
   logic err_m;

   initial begin
      //             r1 u r2 u iss iw ia rv ra dr  s b a e
      tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[1]  = mk(0, 0, 0, 0, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
      tbl[2]  = mk(5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
      tbl[3]  = mk(5, 1, 0, 0, 0, 0, 0, 1, 5, 0, 1, 1, 0, 0);
      tbl[4]  = mk(5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[5]  = mk(0, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[6]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[7]  = mk(0, 0, 0, 0, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
      tbl[8]  = mk(0, 0, 0, 0, 1, 1, 7, 0, 0, 0, 0, 1, 0, 0);
      tbl[9]  = mk(0, 0, 0, 0, 1, 1, 7, 0, 0, 0, 0, 1, 0, 0);
      tbl[10] = mk(0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 1, 1, 0, 0);
      tbl[11] = mk(0, 0, 0, 0, 0, 1, 7, 1, 7, 0, 1, 1, 0, 0);
      tbl[12] = mk(0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 1, 0, 0);
      tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 1, 0, 0);
      tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 1, 0, 0);
      tbl[15] = mk(0, 0, 0, 0, 1, 1, 9, 0, 0, 0, 0, 0, 0, 0);
      tbl[16] = mk(9, 1, 0, 0, 1, 1, 9, 1, 9, 0, 1, 1, 0, 0);
      tbl[17] = mk(0, 0, 9, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
      tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 1, 0, 0);
      tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[20] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      tbl[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle    = tbl[0];

      // reset state while rst_i is held low
      #12;
      $display("reset stall=%0b busy=%0b ack=%0b err=%0b", stall_o, busy_o, drain_ack_o, error_o);
      chk("reset.stall", stall_o, 1'b0);
      chk("reset.busy", busy_o, 1'b0);
      chk("reset.ack", drain_ack_o, 1'b0);
      chk("reset.err", error_o, 1'b0);
      @(negedge clk_i);
      rst_i = 1'b1;

      for (int i = 0; i < 22; i++) step(tbl[i], $sformatf("tbl%0d", i));

      // drain with pending x3/x4, ack after both retire, hold until request drops
      seq.push_back(mk(0, 0, 0, 0, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0));
      seq.push_back(mk(0, 0, 0, 0, 1, 1, 4, 0, 0, 0, 0, 1, 0, 0));
      seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
      seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 1, 1, 1, 0, 0));
      seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 4, 1, 1, 1, 0, 0));
      seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0));
      seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
      seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
      seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      // idle pipeline: ack on the first drain cycle
      seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0));
      seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      // request dropped mid-drain: back to run, no ack
      seq.push_back(mk(0, 0, 0, 0, 1, 1, 3, 0, 0, 1, 0, 0, 0, 0));
      seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0));
      seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
      seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 1, 0, 0));
      seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      // retire with nothing pending: sticky error
      seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 12, 0, 0, 0, 0, 0));
      seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      seq.push_back(mk(0, 0, 0, 0, 1, 1, 3, 0, 0, 1, 0, 0, 0, 1));
      seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1));
      foreach (seq[i]) step(seq[i], $sformatf("seq%0d", i));

      // asynchronous reset in the middle of a drain
      #2;
      rst_i = 1'b0;
      #1;
      $display("midrst stall=%0b busy=%0b ack=%0b err=%0b", stall_o, busy_o, drain_ack_o, error_o);
      chk("midrst.stall", stall_o, 1'b0);
      chk("midrst.busy", busy_o, 1'b0);
      chk("midrst.ack", drain_ack_o, 1'b0);
      chk("midrst.err", error_o, 1'b0);
      @(posedge clk_i);
      #1;
      drive(idle);
      @(negedge clk_i);
      rst_i = 1'b1;
      step(mk(3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "postrst");

      // randomized traffic against the count model
      for (int i = 0; i < 32; i++) cm[i] = 0;
      mode  = 0;
      err_m = 1'b0;
      drain_req_i = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         logic m_busy, m_haz, m_stall, m_ack, iss_ev, dr;
         logic [4:0] r1, r2, ia, ra;
         logic r1u, r2u, iw, iv, ir, rv;
         @(posedge clk_i);
         #1;
         dr = drain_req_i;
         if (!dr) dr = ($urandom_range(0, 19) == 0);
         else if (mode == 2 && $urandom_range(0, 2) == 0) dr = 1'b0;
         else if (mode == 1 && $urandom_range(0, 29) == 0) dr = 1'b0;
         r1 = 5'($urandom_range(0, 7)); r1u = 1'($urandom_range(0, 1));
         r2 = 5'($urandom_range(0, 7)); r2u = 1'($urandom_range(0, 1));
         ia = 5'($urandom_range(0, 7)); iw = ($urandom_range(0, 3) != 0);
         m_busy = 1'b0;
         for (int r = 0; r < 32; r++) if (cm[r] != 0) m_busy = 1'b1;
         m_haz   = (r1u && cm[r1] != 0) || (r2u && cm[r2] != 0) || (iw && cm[ia] == 3);
         m_stall = (mode != 0) || m_haz;
         m_ack   = (mode == 1) && dr && !m_busy;
         iv = !m_stall && ($urandom_range(0, 1) == 1);
         ir = ($urandom_range(0, 3) != 0);
         rv = 1'b0;
         ra = 5'($urandom_range(1, 7));
         if (cm[ra] > 0 && $urandom_range(0, 9) < 5) rv = 1'b1;
         else if ($urandom_range(0, 19) == 0) begin rv = 1'b1; ra = 5'd0; end
         raddr1_i = r1; raddr1_used_i = r1u; raddr2_i = r2; raddr2_used_i = r2u;
         issue_valid_i = iv; issue_ready_i = ir; issue_reg_write_i = iw;
         issue_reg_addr_i = ia; retire_valid_i = rv; retire_reg_addr_i = ra;
         drain_req_i = dr;
         @(negedge clk_i);
         $display("rnd%0d stall=%0b busy=%0b ack=%0b err=%0b", cyc, stall_o, busy_o, drain_ack_o, error_o);
         chk($sformatf("rnd%0d.stall", cyc), stall_o, m_stall);
         chk($sformatf("rnd%0d.busy", cyc), busy_o, m_busy);
         chk($sformatf("rnd%0d.ack", cyc), drain_ack_o, m_ack);
         chk($sformatf("rnd%0d.err", cyc), error_o, err_m);
         // advance the model to what the next edge should commit
         iss_ev = iv && ir && iw && ia != 0;
         if (rv && ra != 0) begin
            if (iss_ev && ia == ra) begin
               // same register issued and retired: net zero
            end else if (cm[ra] == 0) err_m = 1'b1;
            else cm[ra]--;
         end
         if (iss_ev && !(rv && ra == ia)) cm[ia]++;
         case (mode)
            0: if (dr) mode = 1;
            1: if (!dr) mode = 0; else if (!m_busy) mode = 2;
            default: if (!dr) mode = 0;
         endcase
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
